// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared types and defaults for the sprite frame-ROM arbiter.
// Holds the arbiter FSM encoding, default parameters and the ID-width helper.
package sprite_arb_pkg;

  typedef enum logic {ARB, BURST} fsm_t;

  localparam int NUM_REQ_D   = 4;
  localparam int ADDR_W_D    = 19;
  localparam int DATA_W_D    = 24;
  localparam int ROM_LAT_D   = 1;
  localparam int MAX_BURST_D = 16;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester/ROM bundle of the sprite ROM arbiter. The slave side is the arbiter.
// The master side is the sprite draw logic plus the ROM data return.
interface sprite_rom_arbiter_if
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_D,
  parameter int ADDR_W  = ADDR_W_D,
  parameter int DATA_W  = DATA_W_D
) ();

  localparam int IW = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data;
  logic                      rsp_valid;
  logic [IW-1:0]             rsp_id;
  logic [DATA_W-1:0]         rsp_data;

  modport master (
    output req, lock, addr, rom_data,
    input  gnt, rom_addr, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req, lock, addr, rom_data,
    output gnt, rom_addr, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: the first asserted req scanning ptr, ptr+1, ...
// Zero latency. No backpressure; any=0 when nothing is requested.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    j   = 0;
    idx = '0;
    any = 1'b0;
    // Scan in reverse so the closest requester to ptr is written last and wins.
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        idx = IW'(j);
        any = 1'b1;
      end
    end
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin ROM port arbiter with capped locked bursts; grant is same-cycle,
// responses return ROM_LAT cycles later tagged with the requester ID.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_D,
  parameter int ADDR_W    = ADDR_W_D,
  parameter int DATA_W    = DATA_W_D,
  parameter int ROM_LAT   = ROM_LAT_D,
  parameter int MAX_BURST = MAX_BURST_D
) (
  input logic                clk,
  input logic                rst,
  sprite_rom_arbiter_if.slave bus
);

  localparam int IW = id_w(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  fsm_t             fsm;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    ptr;
  logic [CW-1:0]    burst_cnt;
  logic [ROM_LAT-1:0] tag_vld;
  logic [IW-1:0]    tag_id [ROM_LAT];

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               hold;
  logic               win_any;
  logic [IW-1:0]      win;
  logic [IW-1:0]      ptr_next;
  logic [CW-1:0]      cnt_next;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // A locked owner keeps the port only while it still requests.
  assign hold     = (fsm == BURST) && bus.req[owner];
  assign win_any  = !rst && (hold || pick_any);
  assign win      = hold ? owner : pick_idx;
  assign ptr_next = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  assign cnt_next = (fsm == BURST && win == owner) ? burst_cnt + 1'b1 : CW'(1);

  assign bus.gnt      = !win_any ? '0 : (hold ? (NUM_REQ'(1) << owner) : pick_gnt);
  assign bus.rom_addr = win_any ? bus.addr[win*ADDR_W +: ADDR_W] : '0;

  assign bus.rsp_valid = tag_vld[ROM_LAT-1];
  assign bus.rsp_id    = tag_id[ROM_LAT-1];
  assign bus.rsp_data  = bus.rom_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= ARB;
      owner     <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
      tag_vld   <= '0;
      for (int s = 0; s < ROM_LAT; s++) tag_id[s] <= '0;
    end else begin
      if (win_any) begin
        ptr <= ptr_next;
        if (bus.lock[win] && cnt_next < CW'(MAX_BURST)) begin
          fsm       <= BURST;
          owner     <= win;
          burst_cnt <= cnt_next;
        end else begin
          fsm       <= ARB;
          burst_cnt <= '0;
        end
      end else begin
        fsm       <= ARB;
        burst_cnt <= '0;
      end
      tag_vld[0] <= win_any;
      tag_id[0]  <= win;
      for (int s = 1; s < ROM_LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one sprite frame-ROM read port among up to NUM_REQ sprite requesters (player sprites, projectiles, HUD glyphs). Round-robin arbitration with optional locked bursts lets a requester stream a full 16-pixel sprite row without interruption. The ROM has a fixed registered read latency, so the arbiter returns each result tagged with the requester ID. It sits between the per-sprite draw logic and the palette-indexed frame ROM, ahead of the color mapper.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_W, 19: ROM address width.
- DATA_W, 24: RGB pixel width returned by the ROM.
- ROM_LAT, 1: ROM read latency in cycles (≥1).
- MAX_BURST, 16: maximum consecutive grants to one locked owner.
- Clk  in  1: system clock, all state on rising edge.
- Reset  in  1: asynchronous, active-high; clears all state.
- req  in  NUM_REQ: per-requester read request.
- lock  in  NUM_REQ: per-requester burst request, meaningful only with req.
- addr  in  NUM_REQ*ADDR_W: flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ: one-hot (or zero) grant, combinational, same cycle as req.
- rom_addr  out  ADDR_W: address to the ROM, the granted requester's addr, else 0.
- rom_data  in  DATA_W: ROM registered output.
- rsp_valid  out  1: rsp_data carries a result.
- rsp_id  out  $clog2(NUM_REQ): requester that issued the returning read.
- rsp_data  out  DATA_W: rom_data passed through combinationally.

## Operation
- State: fsm ∈ {ARB, BURST}, owner (ID), ptr (ID), burst_cnt ($clog2(MAX_BURST+1) bits), tag pipeline of ROM_LAT stages {valid, id}.
- Grant selection each cycle:
  - BURST and req[owner]=1: grant owner.
  - Otherwise: grant the first i with req[i]=1 scanning ptr, ptr+1, … mod NUM_REQ. No req: gnt=0.
- On every granted cycle with winner g:
  - ptr ← (g+1) mod NUM_REQ.
  - If lock[g]=1 and (cnt_next = (fsm==BURST && g==owner ? burst_cnt+1 : 1)) < MAX_BURST: fsm ← BURST, owner ← g, burst_cnt ← cnt_next.
  - Else: fsm ← ARB, burst_cnt ← 0.
- No grant: fsm ← ARB, burst_cnt ← 0, ptr unchanged.
- Owner dropping req in BURST: falls through to round-robin the same cycle, starting from ptr = owner+1.
- Burst cap: after the MAX_BURST-th consecutive grant, fsm returns to ARB with ptr=owner+1. Other pending requesters win first. If none is pending, owner may start a new burst.
- Tag stage 0 ← {|gnt, g}. Each later stage shifts. rsp_valid/rsp_id = last stage.
- Reset asserted: fsm=ARB, ptr=0, owner=0, burst_cnt=0, all tag valids=0. gnt forced 0 and rom_addr forced 0 while Reset is high.
- In-flight reads at reset are dropped: no rsp_valid for them after Reset deasserts.

## Timing
- Grant latency 0 cycles: req in cycle N → gnt, rom_addr in cycle N.
- Response latency ROM_LAT: rsp_valid, rsp_id, rsp_data in cycle N+ROM_LAT.
- Throughput: one grant per cycle, no bubbles between back-to-back grants, including across burst boundaries.
- Requesters hold req/addr until they see gnt. addr may change every cycle while granted (row streaming).
- Reset values of registered outputs: rsp_valid=0, rsp_id=0.

## Structure
- sprite_arb_pkg: fsm enum {ARB, BURST}, default parameter constants, ID width function.
- Sub-module rr_pick: combinational round-robin picker. Inputs req and ptr; outputs one-hot gnt, index, any. Instanced once.
- Tag pipeline and FSM live in sprite_rom_arbiter.

## Test plan
NUM_REQ=4, ROM_LAT=1, MAX_BURST=16. The ROM model returns data = {5'h0, addr}.
- Reset mid-stream: Reset asserted one cycle after grants to 0 and 1 → rsp_valid=0 throughout and after release, ptr=0. First grant after release goes to the lowest pending ID.
- Round-robin fairness: req=4'b1111 with lock=0 for 8 cycles → grants 0,1,2,3,0,1,2,3. rsp_id matches one cycle later, rsp_data = addr of that requester.
- Burst: req[2]=1 and lock[2]=1 with 16 incrementing addrs, plus req[0]=1 → 16 consecutive grants to 2, then grant 0 at cycle 17, then 2 resumes.
- Burst cap with no contention: req[1]=lock[1]=1 alone for 40 cycles → gnt[1] every cycle, no gap, burst_cnt wraps at 16.
- Owner drop: burst owner 3 drops req at cycle 5 while req[1]=1 → grant 1 that same cycle. No idle cycle.
- Idle gap: no requests for 3 cycles between grants → gnt=0, rom_addr=0, rsp_valid=0 in the corresponding cycles. ptr is retained.
